v_readout: RTL and testbench
============================

# v_readout

Context-list readout engine: accepts a context id, reads that context's `v_pkg::state_t` from the context state table, and streams every valid entry (level, key, volume) in ascending level order over a valid/ready response channel. It is the read side of the list-update path: the update engine writes `state_t` per context via CMD_CLEAR/ADD/DELETE/REPLACE, and this block returns the resulting list contents to the host/report logic. It snoops the table write port so a returned snapshot is never stale relative to a write landing during the read.

## Interface
- `ENTRIES_N`, default `cfg_pkg::ENTRIES_N`: entries per list.
- `CONTEXT_N`, default `cfg_pkg::CONTEXT_N`: contexts in the state table.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_vld`  in  1  readout request valid.
- `req_id`  in  `id_t`  context to read.
- `req_rdy`  out  1  request accepted when `req_vld && req_rdy`.
- `st_rd_en`  out  1  state table read strobe.
- `st_rd_addr`  out  `addr_t`  state table read address.
- `st_rd_data`  in  `STATE_BITS`  read data, valid the cycle after `st_rd_en`; table is read-old on same-address write.
- `st_wr_en`  in  1  snooped table write strobe.
- `st_wr_addr`  in  `addr_t`  snooped write address.
- `st_wr_data`  in  `STATE_BITS`  snooped write data.
- `rsp_vld`  out  1  response beat valid.
- `rsp_rdy`  in  1  response beat consumed when `rsp_vld && rsp_rdy`.
- `rsp_level`  out  `level_t`  entry index of beat.
- `rsp_key`  out  `key_t`  entry key.
- `rsp_volume`  out  `volume_t`  entry volume.
- `rsp_empty`  out  1  list had no valid entry; key/volume/level are zero.
- `rsp_last`  out  1  final beat of this readout.

## Operation
- FSM: IDLE, FETCH, STREAM.
- IDLE: `req_rdy`=1. On handshake: `st_rd_en`=1, `st_rd_addr`=`req_id` (combinational from request), latch id; go FETCH.
- FETCH (one cycle, data returns): snapshot source priority: (1) `st_wr_en && st_wr_addr==id` this cycle -> `st_wr_data`; (2) write to id registered from the accept cycle -> that data; (3) `st_rd_data`. Capture `key`, `volume`, and remaining mask = `vld`; go STREAM.
- STREAM: beat = lowest set bit of remaining mask. `rsp_last` = no other bit set. Mask empty at entry -> single beat with `rsp_empty`=1, `rsp_last`=1. On beat handshake clear that bit; after last handshake go IDLE.
- Writes after FETCH do not alter the snapshot.
- `listsize` is not used for sequencing; `vld` is authoritative. Gaps in `vld` are skipped.
- Response outputs hold stable while `rsp_vld && !rsp_rdy`.

## Timing
- Reset: state IDLE, `req_rdy`=0 during reset, 1 first cycle after; `rsp_vld`, `rsp_last`, `rsp_empty`, `st_rd_en`=0; `rsp_level/key/volume`=0; snapshot and mask cleared.
- Accept at cycle T -> first `rsp_vld` at T+2 (registered).
- Back-to-back beats at full throughput with `rsp_rdy` high: N valid entries occupy T+2..T+N+1.
- Last handshake at cycle L -> `req_rdy`=1 at L+1; next request earliest at L+1 (no overlap).
- `rst` mid-readout aborts: outputs return to reset values next cycle, partial stream is dropped, no further beats.
- Write in accept cycle and in FETCH cycle to same id: FETCH-cycle write wins.

## Structure
- Add to `v_pkg`: `readout_state_t` enum (IDLE/FETCH/STREAM), packed `readout_rsp_t` {level, key, volume, empty, last}.
- Sub-module `v_readout_pri`: parameterised lowest-set-bit priority encoder over `ENTRIES_N`, outputs index, any, and more-than-one-set flag.
- Snapshot held in one `state_t`-shaped register plus remaining-mask register.

## Test plan
- ENTRIES_N=4, ctx 2 vld=4'b1011, keys 10/20/30/40, volumes 1/2/3/4, `rsp_rdy`=1 -> beats (0,10,1),(1,20,2),(3,40,4), last on third, first beat at T+2.
- ctx 5 vld=0 -> single beat `rsp_empty`=1, `rsp_last`=1, key/volume/level 0; `req_rdy` back next cycle.
- `rsp_rdy` toggled 1,0,0,1 on ctx 2 -> outputs stable while stalled; same three beats in order, none duplicated or lost.
- Table write to ctx 2 with vld=4'b0100, key 99 in FETCH cycle -> single beat (2,99,…), last; write to ctx 3 same cycle -> ignored.
- Write to ctx 2 in accept cycle only (RAM returns old) -> snapshot uses written data; write during STREAM -> snapshot unchanged.
- `rst` asserted during second beat -> next cycle `rsp_vld`=0, state IDLE, `req_rdy`=1 after release; fresh request completes normally.

Source files
------------

// File: rtl/v_readout_pkg.sv
// Shared configuration and types for the context-list readout engine.
// cfg_pkg holds the sizing knobs; v_pkg holds the list state layout, the
// readout FSM states, the response beat layout and a beat-building helper.

package cfg_pkg;
    localparam int ENTRIES_N = 4;
    localparam int CONTEXT_N = 8;
endpackage

package v_pkg;
    localparam int E_N      = cfg_pkg::ENTRIES_N;
    localparam int C_N      = cfg_pkg::CONTEXT_N;
    localparam int LEVEL_W  = (E_N > 1) ? $clog2(E_N) : 1;
    localparam int LSIZE_W  = $clog2(E_N + 1);
    localparam int ID_W     = (C_N > 1) ? $clog2(C_N) : 1;
    localparam int KEY_W    = 8;
    localparam int VOLUME_W = 8;

    typedef logic [LEVEL_W-1:0]  level_t;
    typedef logic [ID_W-1:0]     id_t;
    typedef logic [ID_W-1:0]     addr_t;
    typedef logic [KEY_W-1:0]    key_t;
    typedef logic [VOLUME_W-1:0] volume_t;

    // Per-context list state as stored in the context state table.
    typedef struct packed {
        logic [E_N-1:0]           vld;
        logic [LSIZE_W-1:0]       listsize;
        key_t    [E_N-1:0]        key;
        volume_t [E_N-1:0]        volume;
    } state_t;

    localparam int STATE_BITS = $bits(state_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } readout_state_t;

    typedef struct packed {
        level_t  level;
        key_t    key;
        volume_t volume;
        logic    empty;
        logic    last;
    } readout_rsp_t;

    // Build one response beat from a snapshot and the priority-encoder result.
    // An empty mask yields the single all-zero beat flagged empty and last.
    function automatic readout_rsp_t make_beat(input state_t s, input level_t idx,
                                               input logic any, input logic multi);
        readout_rsp_t b;
        b = '0;
        if (any) begin
            b.level  = idx;
            b.key    = s.key[idx];
            b.volume = s.volume[idx];
            b.empty  = 1'b0;
            b.last   = !multi;
        end else begin
            b.empty  = 1'b1;
            b.last   = 1'b1;
        end
        return b;
    endfunction
endpackage

// File: rtl/v_readout_pri.sv
// Lowest-set-bit priority encoder. Reports the index of the lowest set bit,
// whether any bit is set, and whether more than one bit is set (used to tell
// if the selected entry is the final one of the list).

module v_readout_pri #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any   = |mask;
        multi = |(mask & (mask - N'(1'b1)));
    end

endmodule

// File: rtl/v_readout.sv
// Context-list readout engine. Accepts a context id, fetches its list state
// from the context state table and streams every valid entry in ascending
// level order. Table writes are snooped during the accept and fetch cycles so
// the snapshot always reflects the newest data for that context.

module v_readout
    import v_pkg::*;
#(
    parameter int ENTRIES_N = cfg_pkg::ENTRIES_N,
    parameter int CONTEXT_N = cfg_pkg::CONTEXT_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    input  id_t                   req_id,
    output logic                  req_rdy,
    output logic                  st_rd_en,
    output addr_t                 st_rd_addr,
    input  logic [STATE_BITS-1:0] st_rd_data,
    input  logic                  st_wr_en,
    input  addr_t                 st_wr_addr,
    input  logic [STATE_BITS-1:0] st_wr_data,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output level_t                rsp_level,
    output key_t                  rsp_key,
    output volume_t               rsp_volume,
    output logic                  rsp_empty,
    output logic                  rsp_last
);

    readout_state_t        state_r, state_s;
    id_t                   id_r, id_s;
    logic                  acc_hit_r, acc_hit_s;
    state_t                acc_data_r, acc_data_s;
    state_t                snap_r, snap_s;
    logic [ENTRIES_N-1:0]  mask_r, mask_s;
    logic                  req_rdy_r, req_rdy_s;
    logic                  rsp_vld_r, rsp_vld_s;
    readout_rsp_t          rsp_r, rsp_s;

    logic                  accept_s;
    logic                  addr_ok_s;
    logic                  fetch_hit_s;
    state_t                fetch_src_s;
    logic [ENTRIES_N-1:0]  pri_mask_s;
    logic [ENTRIES_N-1:0]  pri_onehot_s;
    level_t                pri_idx_s;
    logic                  pri_any_s;
    logic                  pri_multi_s;
    logic                  listsize_unused_s;

    v_readout_pri #(
        .N (ENTRIES_N)
    ) u_pri (
        .mask  (pri_mask_s),
        .idx   (pri_idx_s),
        .any   (pri_any_s),
        .multi (pri_multi_s)
    );

    // Sequencing runs off the valid mask, so the stored list size is never consulted.
    assign listsize_unused_s = ^snap_r.listsize;

    assign accept_s   = req_vld && req_rdy_r && (state_r == IDLE);
    assign req_rdy    = req_rdy_r;
    assign st_rd_en   = accept_s;
    assign st_rd_addr = req_id;
    assign rsp_vld    = rsp_vld_r;
    assign rsp_level  = rsp_r.level;
    assign rsp_key    = rsp_r.key;
    assign rsp_volume = rsp_r.volume;
    assign rsp_empty  = rsp_r.empty;
    assign rsp_last   = rsp_r.last;

    // Snapshot source for the fetch cycle: a same-cycle write beats a write
    // captured at accept, which beats the (read-old) table data.
    always_comb begin
        addr_ok_s   = (int'(st_wr_addr) < CONTEXT_N);
        fetch_hit_s = st_wr_en && addr_ok_s && (st_wr_addr == id_r);
        if (fetch_hit_s) begin
            fetch_src_s = state_t'(st_wr_data);
        end else if (acc_hit_r) begin
            fetch_src_s = acc_data_r;
        end else begin
            fetch_src_s = state_t'(st_rd_data);
        end
    end

    // Priority encoder input: the fresh valid mask while fetching, otherwise
    // the entries not yet sent.
    always_comb begin
        if (state_r == FETCH) begin
            pri_mask_s = fetch_src_s.vld;
        end else begin
            pri_mask_s = mask_r & snap_r.vld;
        end
        pri_onehot_s = {{(ENTRIES_N-1){1'b0}}, 1'b1} << pri_idx_s;
    end

    // Next-state and datapath update for the IDLE / FETCH / STREAM sequence.
    always_comb begin
        state_s    = state_r;
        id_s       = id_r;
        acc_hit_s  = acc_hit_r;
        acc_data_s = acc_data_r;
        snap_s     = snap_r;
        mask_s     = mask_r;
        req_rdy_s  = req_rdy_r;
        rsp_vld_s  = rsp_vld_r;
        rsp_s      = rsp_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    id_s       = req_id;
                    acc_hit_s  = st_wr_en && addr_ok_s && (st_wr_addr == req_id);
                    acc_data_s = state_t'(st_wr_data);
                    req_rdy_s  = 1'b0;
                    state_s    = FETCH;
                end else begin
                    acc_hit_s  = 1'b0;
                    req_rdy_s  = 1'b1;
                end
            end
            FETCH: begin
                snap_s    = fetch_src_s;
                rsp_s     = make_beat(fetch_src_s, pri_idx_s, pri_any_s, pri_multi_s);
                mask_s    = fetch_src_s.vld & ~pri_onehot_s;
                rsp_vld_s = 1'b1;
                acc_hit_s = 1'b0;
                state_s   = STREAM;
            end
            STREAM: begin
                if (rsp_vld_r && rsp_rdy) begin
                    if (rsp_r.last) begin
                        rsp_vld_s = 1'b0;
                        rsp_s     = '0;
                        mask_s    = '0;
                        req_rdy_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        rsp_s  = make_beat(snap_r, pri_idx_s, pri_any_s, pri_multi_s);
                        mask_s = mask_r & ~pri_onehot_s;
                    end
                end else begin
                    rsp_s = rsp_r;
                end
            end
            default: begin
                rsp_vld_s = 1'b0;
                rsp_s     = '0;
                mask_s    = '0;
                acc_hit_s = 1'b0;
                req_rdy_s = 1'b1;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any readout in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            id_r       <= '0;
            acc_hit_r  <= 1'b0;
            acc_data_r <= '0;
            snap_r     <= '0;
            mask_r     <= '0;
            req_rdy_r  <= 1'b0;
            rsp_vld_r  <= 1'b0;
            rsp_r      <= '0;
        end else begin
            state_r    <= state_s;
            id_r       <= id_s;
            acc_hit_r  <= acc_hit_s;
            acc_data_r <= acc_data_s;
            snap_r     <= snap_s;
            mask_r     <= mask_s;
            req_rdy_r  <= req_rdy_s;
            rsp_vld_r  <= rsp_vld_s;
            rsp_r      <= rsp_s;
        end
    end

endmodule

// File: tb/tb_v_readout.sv
// Directed testbench for v_readout: a small read-old state table model,
// per-scenario tasks with hand-computed expected beats.

module tb_v_readout;
    import v_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_vld;
    id_t                   req_id;
    logic                  req_rdy;
    logic                  st_rd_en;
    addr_t                 st_rd_addr;
    logic [STATE_BITS-1:0] st_rd_data;
    logic                  st_wr_en;
    addr_t                 st_wr_addr;
    logic [STATE_BITS-1:0] st_wr_data;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    level_t                rsp_level;
    key_t                  rsp_key;
    volume_t               rsp_volume;
    logic                  rsp_empty;
    logic                  rsp_last;

    int errors = 0;
    int checks = 0;

    state_t mem [0:cfg_pkg::CONTEXT_N-1];

    // Collected handshaken beats.
    int      got_n;
    int      first_c;
    int      stab_err;
    level_t  g_lvl  [8];
    key_t    g_key  [8];
    volume_t g_vol  [8];
    logic    g_last [8];
    logic    g_emp  [8];

    state_t d_a, d_e, d_x, d_b, d_c, d_d;

    always #5 clk = ~clk;

    v_readout dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_id     (req_id),
        .req_rdy    (req_rdy),
        .st_rd_en   (st_rd_en),
        .st_rd_addr (st_rd_addr),
        .st_rd_data (st_rd_data),
        .st_wr_en   (st_wr_en),
        .st_wr_addr (st_wr_addr),
        .st_wr_data (st_wr_data),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_level  (rsp_level),
        .rsp_key    (rsp_key),
        .rsp_volume (rsp_volume),
        .rsp_empty  (rsp_empty),
        .rsp_last   (rsp_last)
    );

    // Context state table: one-cycle read, read-old on same-address write.
    always @(posedge clk) begin
        if (st_rd_en) st_rd_data <= mem[st_rd_addr];
        if (st_wr_en) mem[st_wr_addr] <= state_t'(st_wr_data);
    end

    function automatic state_t mk(input logic [3:0] vld, input logic [2:0] ls,
                                  input key_t k0, input key_t k1, input key_t k2, input key_t k3,
                                  input volume_t v0, input volume_t v1, input volume_t v2, input volume_t v3);
        state_t s;
        s = '0;
        s.vld = vld; s.listsize = ls;
        s.key[0] = k0; s.key[1] = k1; s.key[2] = k2; s.key[3] = k3;
        s.volume[0] = v0; s.volume[1] = v1; s.volume[2] = v2; s.volume[3] = v3;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input id_t id, input state_t d);
        st_wr_en = 1'b1; st_wr_addr = id; st_wr_data = d;
        tick();
        st_wr_en = 1'b0;
    endtask

    task automatic request(input id_t id, input logic wr, input id_t waddr, input state_t wdata);
        req_vld = 1'b1; req_id = id;
        st_wr_en = wr; st_wr_addr = waddr; st_wr_data = wdata;
        tick();
        req_vld = 1'b0; st_wr_en = 1'b0;
    endtask

    // Starts in the fetch cycle (c=0). Drives rsp_rdy from rdy_pat (LSB first,
    // then 1) and an optional write at cycle wr_c; records handshaken beats
    // and any output change while stalled. Bounded by a cycle budget.
    task automatic collect(input logic [7:0] rdy_pat, input int wr_c,
                           input id_t waddr, input state_t wdata);
        logic [63:0] prev, cur;
        logic        prev_stall;
        logic        done;
        prev = '0; prev_stall = 1'b0; done = 1'b0;
        got_n = 0; first_c = -1; stab_err = 0;
        for (int c = 0; c < 24 && !done; c++) begin
            rsp_rdy    = (c < 8) ? rdy_pat[c] : 1'b1;
            st_wr_en   = (c == wr_c);
            st_wr_addr = waddr;
            st_wr_data = wdata;
            cur = 64'({rsp_vld, rsp_level, rsp_key, rsp_volume, rsp_empty, rsp_last});
            if (rsp_vld && first_c < 0) first_c = c;
            if (prev_stall && cur != prev) stab_err++;
            prev = cur;
            prev_stall = rsp_vld && !rsp_rdy;
            if (rsp_vld && rsp_rdy && got_n < 8) begin
                g_lvl[got_n] = rsp_level; g_key[got_n] = rsp_key; g_vol[got_n] = rsp_volume;
                g_last[got_n] = rsp_last; g_emp[got_n] = rsp_empty;
                got_n++;
                if (rsp_last) done = 1'b1;
            end
            tick();
        end
        st_wr_en = 1'b0;
        rsp_rdy  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_rdy, rsp_vld, rsp_last, rsp_empty, st_rd_en} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctl: got rdy/vld/last/empty/rd_en=%b want 00000",
                     {req_rdy, rsp_vld, rsp_last, rsp_empty, st_rd_en});
        end
        checks++;
        if ({rsp_level, rsp_key, rsp_volume} !== '0) begin
            errors++;
            $display("FAIL reset_data: got lvl=%0d key=%0d vol=%0d want 0/0/0", rsp_level, rsp_key, rsp_volume);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got req_rdy=%b want 1", req_rdy);
        end
    endtask

    task automatic test_basic();
        level_t  e_lvl [3] = '{2'd0, 2'd1, 2'd3};
        key_t    e_key [3] = '{8'd10, 8'd20, 8'd40};
        volume_t e_vol [3] = '{8'd1, 8'd2, 8'd4};
        logic    e_last[3] = '{1'b0, 1'b0, 1'b1};
        req_vld = 1'b1; req_id = 3'd2;
        #1;
        checks++;
        if (st_rd_en !== 1'b1 || st_rd_addr !== 3'd2) begin
            errors++;
            $display("FAIL basic_rd: got en=%b addr=%0d want en=1 addr=2", st_rd_en, st_rd_addr);
        end
        tick();
        req_vld = 1'b0;
        collect(8'hFF, -1, 3'd0, '0);
        checks++;
        if (first_c != 1) begin
            errors++;
            $display("FAIL basic_latency: got first beat at T+%0d want T+2", first_c + 1);
        end
        checks++;
        if (got_n != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d beats want 3", got_n);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (g_lvl[b] !== e_lvl[b] || g_key[b] !== e_key[b] || g_vol[b] !== e_vol[b] ||
                g_last[b] !== e_last[b] || g_emp[b] !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: got (%0d,%0d,%0d) last=%b empty=%b want (%0d,%0d,%0d) last=%b empty=0",
                         b, g_lvl[b], g_key[b], g_vol[b], g_last[b], g_emp[b], e_lvl[b], e_key[b], e_vol[b], e_last[b]);
            end
        end
        checks++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got req_rdy=%b rsp_vld=%b want 1/0", req_rdy, rsp_vld);
        end
    endtask

    task automatic test_empty();
        request(3'd5, 1'b0, 3'd0, '0);
        collect(8'hFF, -1, 3'd0, '0);
        checks++;
        if (got_n != 1 || first_c != 1) begin
            errors++;
            $display("FAIL empty_count: got %0d beats first at c=%0d want 1 beat at c=1", got_n, first_c);
        end
        checks++;
        if (g_emp[0] !== 1'b1 || g_last[0] !== 1'b1 || g_lvl[0] !== 2'd0 ||
            g_key[0] !== 8'd0 || g_vol[0] !== 8'd0) begin
            errors++;
            $display("FAIL empty_beat: got (%0d,%0d,%0d) empty=%b last=%b want (0,0,0) empty=1 last=1",
                     g_lvl[0], g_key[0], g_vol[0], g_emp[0], g_last[0]);
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL empty_rdy: got req_rdy=%b want 1", req_rdy);
        end
    endtask

    task automatic test_stall();
        key_t e_key [3] = '{8'd10, 8'd20, 8'd40};
        request(3'd2, 1'b0, 3'd0, '0);
        collect(8'hF3, -1, 3'd0, '0);
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d output changes while stalled want 0", stab_err);
        end
        checks++;
        if (got_n != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d beats want 3", got_n);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (g_key[b] !== e_key[b] || g_last[b] !== (b == 2)) begin
                errors++;
                $display("FAIL stall_beat%0d: got key=%0d last=%b want key=%0d last=%b",
                         b, g_key[b], g_last[b], e_key[b], (b == 2));
            end
        end
    endtask

    task automatic test_fetch_write();
        request(3'd2, 1'b1, 3'd2, d_x);
        collect(8'hFF, 0, 3'd2, d_b);
        checks++;
        if (got_n != 1 || g_lvl[0] !== 2'd2 || g_key[0] !== 8'd99 || g_vol[0] !== 8'd9 || g_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wr: got n=%0d (%0d,%0d,%0d) last=%b want n=1 (2,99,9) last=1",
                     got_n, g_lvl[0], g_key[0], g_vol[0], g_last[0]);
        end
        request(3'd2, 1'b0, 3'd0, '0);
        collect(8'hFF, 0, 3'd3, d_x);
        checks++;
        if (got_n != 1 || g_lvl[0] !== 2'd2 || g_key[0] !== 8'd99) begin
            errors++;
            $display("FAIL fetch_other: got n=%0d (%0d,%0d) want n=1 (2,99)", got_n, g_lvl[0], g_key[0]);
        end
    endtask

    task automatic test_accept_write();
        request(3'd2, 1'b1, 3'd2, d_c);
        collect(8'hFF, -1, 3'd0, '0);
        checks++;
        if (got_n != 2 || g_lvl[0] !== 2'd0 || g_key[0] !== 8'd50 || g_vol[0] !== 8'd5 ||
            g_lvl[1] !== 2'd1 || g_key[1] !== 8'd60 || g_vol[1] !== 8'd6 || g_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL accept_wr: got n=%0d (%0d,%0d,%0d)(%0d,%0d,%0d) want n=2 (0,50,5)(1,60,6)",
                     got_n, g_lvl[0], g_key[0], g_vol[0], g_lvl[1], g_key[1], g_vol[1]);
        end
        request(3'd2, 1'b0, 3'd0, '0);
        collect(8'hFF, 1, 3'd2, d_d);
        checks++;
        if (got_n != 2 || g_key[0] !== 8'd50 || g_key[1] !== 8'd60 || g_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL stream_wr: got n=%0d keys %0d,%0d want n=2 keys 50,60", got_n, g_key[0], g_key[1]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        load(3'd2, d_a);
        rsp_rdy = 1'b1;
        request(3'd2, 1'b0, 3'd0, '0);
        tick();
        tick();
        checks++;
        if (rsp_vld !== 1'b1 || rsp_key !== 8'd20) begin
            errors++;
            $display("FAIL rstmid_pre: got vld=%b key=%0d want vld=1 key=20", rsp_vld, rsp_key);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (rsp_vld !== 1'b0 || rsp_last !== 1'b0 || req_rdy !== 1'b0 || {rsp_level, rsp_key, rsp_volume} !== '0) begin
            errors++;
            $display("FAIL rstmid_abort: got vld=%b last=%b rdy=%b key=%0d want 0/0/0/0",
                     rsp_vld, rsp_last, req_rdy, rsp_key);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got req_rdy=%b rsp_vld=%b want 1/0", req_rdy, rsp_vld);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_vld === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d stray beats want 0", seen);
        end
        request(3'd2, 1'b0, 3'd0, '0);
        collect(8'hFF, -1, 3'd0, '0);
        checks++;
        if (got_n != 3 || g_key[0] !== 8'd10 || g_key[1] !== 8'd20 || g_key[2] !== 8'd40 || g_last[2] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fresh: got n=%0d keys %0d,%0d,%0d want n=3 keys 10,20,40",
                     got_n, g_key[0], g_key[1], g_key[2]);
        end
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_id = '0; rsp_rdy = 1'b0;
        st_wr_en = 1'b0; st_wr_addr = '0; st_wr_data = '0;
        d_a = mk(4'b1011, 3'd3, 8'd10, 8'd20, 8'd30, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4);
        d_e = mk(4'b0000, 3'd2, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
        d_x = mk(4'b0001, 3'd1, 8'd11, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0);
        d_b = mk(4'b0100, 3'd1, 8'd0, 8'd0, 8'd99, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0);
        d_c = mk(4'b0011, 3'd2, 8'd50, 8'd60, 8'd0, 8'd0, 8'd5, 8'd6, 8'd0, 8'd0);
        d_d = mk(4'b1000, 3'd1, 8'd0, 8'd0, 8'd0, 8'd88, 8'd0, 8'd0, 8'd0, 8'd8);
        test_reset();
        load(3'd2, d_a);
        load(3'd5, d_e);
        rsp_rdy = 1'b1;
        test_basic();
        test_empty();
        test_stall();
        test_fetch_write();
        test_accept_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
